inst_ram_loader: RTL and testbench

Upstream boot loader for the single-cycle CPU's instruction RAM. It holds the CPU in reset, receives a program image as a byte stream over a valid/ready handshake, and packs the bytes into 32-bit words. It writes each word into the instruction `async_ram` through its write port and checks a trailing XOR checksum. On success it releases the CPU reset so execution begins from word 0.

---
 rtl/inst_ram_loader_pkg.sv | 21 ++
 rtl/inst_ram_loader_packer.sv | 59 +++++
 rtl/inst_ram_loader.sv | 164 ++++++++++++++++
 tb/tb_inst_ram_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_ram_loader_pkg.sv
// Shared constants and state encoding for the instruction RAM boot loader.
package inst_ram_loader_pkg;

  localparam int unsigned MAX_WORDS_DEFAULT = 1024;
  localparam int unsigned HDR_LEN           = 2;
  localparam int unsigned BYTES_PER_WORD    = 4;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned CNT_W             = 16;
  localparam int unsigned BCNT_W            = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_RUN  = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

endpackage

// File: rtl/inst_ram_loader_packer.sv
// Packs little-endian bytes into 32-bit words; emits a registered 1-cycle strobe per word.
module byte_to_word_packer
  import inst_ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              accept_i,
  input  logic              clear_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  // Next-state: place each byte in its lane; the 4th byte completes the word.
  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (accept_i) begin
      cnt_d = cnt_q + BCNT_W'(1);
      case (cnt_q)
        2'd0:    asm_d[7:0]   = byte_i;
        2'd1:    asm_d[15:8]  = byte_i;
        2'd2:    asm_d[23:16] = byte_i;
        default: begin
          word_d  = {byte_i, asm_q};
          valid_d = 1'b1;
        end
      endcase
    end
  end

  // Packer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/inst_ram_loader.sv
// Boot loader: receives a counted, XOR-checked byte image, writes it to instruction RAM,
// then releases the CPU reset.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              cpu_resetn,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] cnt_lo_q, cnt_lo_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;
  logic              cpu_resetn_q, cpu_resetn_d;
  logic              error_q, error_d;
  logic              hs;
  logic [CNT_W-1:0]  n_rx;
  logic              last_byte;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign hs        = in_valid & in_ready_q;
  assign n_rx      = {in_data, cnt_lo_q};
  assign last_byte = (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) &&
                     (word_idx_q == CNT_W'(n_q - CNT_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_HDR0;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR0: if (hs) state_d = ST_HDR1;
      ST_HDR1: if (hs) begin
        if (n_rx > CNT_W'(MAX_WORDS)) state_d = ST_ERR;
        else if (n_rx == '0)          state_d = ST_CSUM;
        else                          state_d = ST_DATA;
      end
      ST_DATA: if (hs && last_byte) state_d = ST_CSUM;
      ST_CSUM: if (hs) state_d = ((xor_q ^ in_data) == '0) ? ST_RUN : ST_ERR;
      ST_RUN:  state_d = ST_RUN;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase
  end

  // Output decode from the next state so every output is registered.
  always_comb begin
    in_ready_d   = 1'b0;
    done_d       = 1'b0;
    cpu_resetn_d = 1'b0;
    error_d      = 1'b0;
    case (state_d)
      ST_HDR0, ST_HDR1, ST_DATA, ST_CSUM: in_ready_d = 1'b1;
      ST_RUN: begin
        done_d       = 1'b1;
        cpu_resetn_d = 1'b1;
      end
      ST_ERR:  error_d = 1'b1;
      default: error_d = 1'b1;
    endcase
  end

  // Datapath next-state: header capture, word/byte counters, running XOR, write address.
  always_comb begin
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    xor_d      = xor_q;
    addr_d     = addr_q;
    if (hs) begin
      case (state_q)
        ST_HDR0: begin
          cnt_lo_d = in_data;
          xor_d    = xor_q ^ in_data;
        end
        ST_HDR1: begin
          n_d        = n_rx;
          word_idx_d = '0;
          byte_cnt_d = '0;
          xor_d      = xor_q ^ in_data;
        end
        ST_DATA: begin
          xor_d      = xor_q ^ in_data;
          byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          if (byte_cnt_q == BCNT_W'(BYTES_PER_WORD - 1)) begin
            addr_d     = WORD_W'({word_idx_q, 2'b00});
            word_idx_d = word_idx_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_lo_q     <= '0;
      n_q          <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      xor_q        <= '0;
      addr_q       <= '0;
      in_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      cpu_resetn_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      cnt_lo_q     <= cnt_lo_d;
      n_q          <= n_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      xor_q        <= xor_d;
      addr_q       <= addr_d;
      in_ready_q   <= in_ready_d;
      done_q       <= done_d;
      cpu_resetn_q <= cpu_resetn_d;
      error_q      <= error_d;
    end
  end

  byte_to_word_packer u_packer (
    .clk          (clk),
    .resetn       (resetn),
    .byte_i       (in_data),
    .accept_i     (hs && (state_q == ST_DATA)),
    .clear_i      (hs && (state_q == ST_HDR1)),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  assign ram_en     = 1'b1;
  assign ram_wen    = {4{word_valid}};
  assign ram_addr   = addr_q;
  assign ram_wdata  = word;
  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign cpu_resetn = cpu_resetn_q;
  assign error      = error_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Directed bench for inst_ram_loader with a write scoreboard.
module tb_inst_ram_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        cpu_resetn;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;
  int writes_seen = 0;
  wr_t exp_q[$];
  logic [7:0] frm[$];

  always #5 clk = ~clk;

  inst_ram_loader dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .ram_en     (ram_en),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .cpu_resetn (cpu_resetn),
    .done       (done),
    .error      (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected (addr, data).
  always @(negedge clk) begin
    if (resetn && ram_wen !== 4'h0) begin
      wr_t e;
      writes_seen++;
      check("wen_value", 32'(ram_wen), 32'hf);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", ram_addr, e.addr);
        check("wr_data", ram_wdata, e.data);
      end
    end
  end

  // Build a frame with header count n, payload words and XOR checksum (optionally corrupted).
  task automatic build_frame(input logic [15:0] n, input logic [31:0] words[$], input bit bad);
    logic [7:0] x;
    frm.delete();
    frm.push_back(n[7:0]);
    frm.push_back(n[15:8]);
    foreach (words[w]) begin
      for (int b = 0; b < 4; b++) begin
        logic [31:0] wv;
        wv = words[w];
        frm.push_back(wv[8*b +: 8]);
      end
    end
    x = 8'h00;
    foreach (frm[i]) x = x ^ frm[i];
    frm.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // Entry and exit at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send the first nbytes of frm; expected writes are pushed for every word fully sent.
  task automatic send_frame(input int nbytes, input bit gaps);
    int nw;
    nw = int'({frm[1], frm[0]});
    for (int w = 0; w < nw && (2 + 4 * w + 3) < nbytes; w++) begin
      wr_t e;
      e.addr = 32'(w * 4);
      e.data = {frm[2+4*w+3], frm[2+4*w+2], frm[2+4*w+1], frm[2+4*w]};
      exp_q.push_back(e);
    end
    for (int i = 0; i < nbytes; i++) begin
      send_byte(frm[i], gaps);
      if (i >= 2 && i < 2 + 4 * nw && ((i - 2) % 4) == 3)
        check("wr_strobe_timing", 32'(ram_wen), 32'hf);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] two[$];
    logic [31:0] one[$];
    logic [31:0] none[$];
    int base;
    two = '{32'h12345678, 32'hDEADBEEF};
    one = '{32'h11223344};

    // Reset state, clock running.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ram_en", 32'(ram_en), 32'd1);
    check("rst_ram_wen", 32'(ram_wen), 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Two-word load.
    base = writes_seen;
    build_frame(16'd2, two, 1'b0);
    send_frame(frm.size() - 1, 1'b0);
    check("good_done_before_csum", 32'(done), 32'd0);
    send_byte(frm[frm.size()-1], 1'b0);
    check("good_done", 32'(done), 32'd1);
    check("good_cpu_resetn", 32'(cpu_resetn), 32'd1);
    check("good_in_ready", 32'(in_ready), 32'd0);
    check("good_error", 32'(error), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("good_writes", 32'(writes_seen - base), 32'd2);
    check("good_sb_drained", 32'(exp_q.size()), 32'd0);

    // Bad checksum.
    apply_reset();
    base = writes_seen;
    build_frame(16'd2, two, 1'b1);
    send_frame(frm.size(), 1'b0);
    check("bad_error", 32'(error), 32'd1);
    check("bad_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("bad_done", 32'(done), 32'd0);
    check("bad_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bad_ignored_writes", 32'(writes_seen - base), 32'd2);
    check("bad_error_sticky", 32'(error), 32'd1);
    check("bad_sb_drained", 32'(exp_q.size()), 32'd0);

    // Empty image.
    apply_reset();
    base = writes_seen;
    build_frame(16'd0, none, 1'b0);
    send_frame(frm.size(), 1'b0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_cpu_resetn", 32'(cpu_resetn), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("empty_writes", 32'(writes_seen - base), 32'd0);

    // Oversize count.
    apply_reset();
    base = writes_seen;
    build_frame(16'd1025, none, 1'b0);
    send_byte(frm[0], 1'b0);
    check("over_error_early", 32'(error), 32'd0);
    send_byte(frm[1], 1'b0);
    check("over_error", 32'(error), 32'd1);
    check("over_in_ready", 32'(in_ready), 32'd0);
    check("over_cpu_resetn", 32'(cpu_resetn), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("over_writes", 32'(writes_seen - base), 32'd0);

    // Backpressure gaps.
    apply_reset();
    base = writes_seen;
    build_frame(16'd2, two, 1'b0);
    send_frame(frm.size(), 1'b1);
    check("gap_done", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("gap_writes", 32'(writes_seen - base), 32'd2);
    check("gap_sb_drained", 32'(exp_q.size()), 32'd0);

    // Mid-frame reset after 6 data bytes, then a good one-word frame.
    apply_reset();
    base = writes_seen;
    build_frame(16'd2, two, 1'b0);
    send_frame(8, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_wen", 32'(ram_wen), 32'd0);
    check("mid_rst_addr", ram_addr, 32'd0);
    check("mid_rst_wdata", ram_wdata, 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_first_writes", 32'(writes_seen - base), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    base = writes_seen;
    build_frame(16'd1, one, 1'b0);
    send_frame(frm.size(), 1'b0);
    check("mid_done", 32'(done), 32'd1);
    check("mid_cpu_resetn", 32'(cpu_resetn), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("mid_second_writes", 32'(writes_seen - base), 32'd1);
    check("mid_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
